// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational read ports, two write ports, x0 hardwired to zero.
// After reset a CLEAR sequence zeroes x1..x(NREGS-1); optional write-to-read bypass via REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NR    = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    output logic               dbg_state,
    input  logic               we0,
    input  logic [AW-1:0]      wa0,
    input  logic [XLEN-1:0]    wd0,
    input  logic               we1,
    input  logic [AW-1:0]      wa1,
    input  logic [XLEN-1:0]    wd1,
    input  logic [NR*AW-1:0]   ra,
    output logic [NR*XLEN-1:0] rd
);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] regs [NREGS];
    logic            wen0;
    logic            wen1;

    // Handshake: a write is accepted on an edge only when weN is high, ready is high
    // and rst is low; no back-pressure exists, writes offered while ready is low are dropped.
    assign ready     = (state == READY);
    assign dbg_state = (state == READY);
    assign wen0      = ready && we0 && (wa0 != '0);
    assign wen1      = ready && we1 && (wa1 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= AW'(1);
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == AW'(NREGS - 1))
                state <= READY;
        end
    end

    // Storage has no reset of its own; the CLEAR walk zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end else begin
                if (wen0) regs[wa0] <= wd0;
                if (wen1) regs[wa1] <= wd1;
            end
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] q;
        assign a = ra[i*AW +: AW];
        always_comb begin
            q = '0;
            if (ready && (a != '0)) begin
                q = regs[a];
`ifdef REGFILE_BYPASS_EN
                if (wen1 && (wa1 == a))
                    q = wd1;
                else if (wen0 && (wa0 == a))
                    q = wd0;
`endif
            end
        end
        assign rd[i*XLEN +: XLEN] = q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: abstract model plus per-cycle compare, and directed literal checks.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NR    = 2;
    localparam int AW    = 5;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               ready, dbg_state;
    logic               we0, we1;
    logic [AW-1:0]      wa0, wa1;
    logic [XLEN-1:0]    wd0, wd1;
    logic [NR*AW-1:0]   ra;
    logic [NR*XLEN-1:0] rd;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR)) dut (
        .clk(clk), .rst(rst), .ready(ready), .dbg_state(dbg_state),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // model: edges-since-reset counter, flat memory image, writes applied in port order
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_valid = 0;
    bit              m_ready = 0;
    int              m_cnt   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_ready = 0;
            m_cnt   = 0;
        end else if (m_valid && !m_ready) begin
            m_cnt++;
            if (m_cnt == NREGS - 1) begin
                m_ready = 1;
                for (int k = 0; k < NREGS; k++) m_mem[k] = '0;
            end
        end else if (m_ready) begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
        end
    end

    function automatic logic [XLEN-1:0] model_rd(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (!m_ready || a == 0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == a) v = wd1;
        else if (we0 && wa0 == a) v = wd0;
`endif
        return v;
    endfunction

    // compare process, sampled on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_ready", {31'd0, ready}, {31'd0, m_ready});
            for (int p = 0; p < NR; p++)
                chk("cyc_rd", rd[p*XLEN +: XLEN], model_rd(ra[p*AW +: AW]));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        ra = {a1, a0};
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        chk(name, XLEN'(n), XLEN'(31));
    endtask

    initial begin
        idle();
        ra  = '0;
        rst = 1;
        tick();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        rst = 0;
        wait_ready("ready_latency");

        // every register reads zero after clear
        for (int i = 0; i < NREGS; i++) exp_q.push_back('0);
        for (int i = 0; i < NREGS; i++) begin
            logic [AW-1:0] a = i[AW-1:0];
            set_ra(a, a);
            chk("clear_rd0", rd[XLEN-1:0], exp_q.pop_front());
        end

        // x5 on port 0, read on all ports
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra = {5'd5, 5'd5};
        tick();
        idle();
        #1;
        chk("x5_p0", rd[31:0], 32'hDEADBEEF);
        chk("x5_p1", rd[63:32], 32'hDEADBEEF);

        // x0 stays zero
        we0 = 1; wa0 = 0; wd0 = 32'h1234; we1 = 1; wa1 = 0; wd1 = 32'h5678;
        tick();
        idle();
        set_ra(5'd0, 5'd0);
        chk("x0_zero", rd[31:0], 32'h0);

        // same-address collision, port 1 wins
        we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
        tick();
        idle();
        set_ra(5'd7, 5'd7);
        chk("x7_prio", rd[63:32], 32'h22);

        // distinct addresses in one cycle
        we0 = 1; wa0 = 10; wd0 = 32'hAAAA; we1 = 1; wa1 = 11; wd1 = 32'hBBBB;
        tick();
        idle();
        set_ra(5'd11, 5'd10);
        chk("x10", rd[31:0], 32'hAAAA);
        chk("x11", rd[63:32], 32'hBBBB);

        // same-cycle read of a write in flight
        set_ra(5'd3, 5'd0);
        we0 = 1; wa0 = 3; wd0 = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x3_same_cycle", rd[63:32], 32'hA5A5A5A5);
`else
        chk("x3_same_cycle", rd[63:32], 32'h0);
`endif
        tick();
        idle();
        #1;
        chk("x3_next", rd[63:32], 32'hA5A5A5A5);

        // reset mid-clear at clr_cnt = 10, writes during clear dropped
        rst = 1;
        tick();
        rst = 0;
        repeat (9) tick();
        rst = 1;
        tick();
        rst = 0;
        we0 = 1; wa0 = 9; wd0 = 32'h55;
        repeat (5) tick();
        idle();
        begin
            int n = 5;
            while (!ready && n < 100) begin
                tick();
                n++;
            end
            chk("midclear_latency", XLEN'(n), XLEN'(31));
        end
        set_ra(5'd9, 5'd5);
        chk("x9_dropped", rd[63:32], 32'h0);
        chk("x5_cleared", rd[31:0], 32'h0);

        // contents cleared by a reset from READY
        we1 = 1; wa1 = 4; wd1 = 32'hFF;
        tick();
        idle();
        set_ra(5'd4, 5'd4);
        chk("x4_written", rd[31:0], 32'hFF);
        rst = 1;
        we0 = 1; wa0 = 4; wd0 = 32'h77;
        tick();
        idle();
        rst = 0;
        #1;
        chk("x4_during_clear", rd[31:0], 32'h0);
        wait_ready("ready_latency2");
        #1;
        chk("x4_after_reset", rd[31:0], 32'h0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; power of two, >= 2.
REQ-003 SHALL have parameter NR, default 2, meaning number of read ports, >= 1.
REQ-004 SHALL derive AW = clog2(NREGS) as the address width.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port ready  output  1  high when the clear sequence is complete and the file accepts writes.
REQ-008 SHALL have port we0  input  1  write enable, write port 0.
REQ-009 SHALL have port wa0  input  AW  write address, write port 0.
REQ-010 SHALL have port wd0  input  XLEN  write data, write port 0.
REQ-011 SHALL have ports we1, wa1, wd1  input  1/AW/XLEN  write port 1; same meanings as write port 0.
REQ-012 SHALL have port ra  input  NR*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-013 SHALL have port rd  output  NR*XLEN  packed read data; port i at bits [i*XLEN +: XLEN].

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY; ready = (state == READY).
REQ-015 SHALL, in CLEAR with rst low, zero register clr_cnt on each edge and increment clr_cnt; clr_cnt starts at 1.
REQ-016 SHALL move from CLEAR to READY on the edge that clears register NREGS-1; ready is high exactly NREGS-1 edges after rst falls (31 at defaults).
REQ-017 SHALL ignore we0 and we1 while ready is low.
REQ-018 SHALL drive every rd port to 0 while ready is low.
REQ-019 SHALL, when ready is high, write wdN to register waN on the edge when weN = 1 and waN != 0.
REQ-020 SHALL never write register 0, and every read of address 0 SHALL return 0.
REQ-021 SHALL, when we0 and we1 both target the same nonzero address in one cycle, store wd1 (port 1 has priority).
REQ-022 SHALL apply two writes to distinct addresses in the same cycle independently.
REQ-023 SHALL make each read port combinational and independent; any number of ports may read the same address.

Reset
REQ-024 SHALL, on any edge with rst high, set state to CLEAR, clr_cnt to 1 and ready to 0; register contents need not change on that edge.
REQ-025 SHALL restart the clear sequence when rst is asserted mid-clear or in READY; writes in that cycle are discarded.
REQ-026 SHALL hold ready at 0 and all rd at 0 from the first edge with rst high until the clear sequence completes.

Configuration
REQ-027 SHALL, with macro REGFILE_BYPASS_EN defined, forward same-cycle write data to any read port whose nonzero address matches an enabled write while ready is high; port 1 data wins a dual match.
REQ-028 SHALL, without REGFILE_BYPASS_EN, return only stored contents, so a written value appears on rd from the cycle after the write edge.

Verification
REQ-029 SHALL cover this case: pulse rst for 1 cycle, then count edges -> ready rises after exactly 31 edges; all 32 registers then read 0.
REQ-030 SHALL cover this case: once ready, write 0xDEADBEEF to x5 on port 0 and read x5 on all ports next cycle -> 0xDEADBEEF; write 0x1234 to x0 -> x0 still reads 0.
REQ-031 SHALL cover this case: same cycle, port 0 writes x7 = 0x11 and port 1 writes x7 = 0x22 -> x7 reads 0x22 next cycle.
REQ-032 SHALL cover this case: with the macro defined, write x3 = 0xA5A5A5A5 while ra port 1 = 3 -> rd port 1 = 0xA5A5A5A5 in the same cycle; without the macro -> old value, then 0xA5A5A5A5 next cycle.
REQ-033 SHALL cover this case: assert rst when clr_cnt = 10, then write x9 = 0x55 during the clear -> ready rises 31 edges after rst falls and x9 reads 0.
REQ-034 SHALL cover this case: write x4 = 0xFF and x4 reads 0xFF, then rst -> after ready rises again, x4 reads 0.
